// File: rtl/ita_inp2_buf_pkg.sv
// Shared types and default sizes for the double-buffered PE-array weight operand stage.
package ita_inp2_buf_pkg;

    localparam int unsigned INP2_N  = 64;
    localparam int unsigned INP2_WI = 8;
    localparam int unsigned INP2_RW = 8;

    typedef enum logic {
        INP2_BUF    = 1'b0,
        INP2_BYPASS = 1'b1
    } inp2_mode_e;

    typedef logic [INP2_RW-1:0]                reuse_t;
    typedef logic [INP2_N-1:0][INP2_WI-1:0]    weight_t;

endpackage

// File: rtl/ita_inp2_buf_if.sv
// Weight-tile handshake and PE-array operand bundle for ita_inp2_buf.
interface ita_inp2_buf_if
    import ita_inp2_buf_pkg::*;
#(
    parameter int unsigned N  = INP2_N,
    parameter int unsigned WI = INP2_WI,
    parameter int unsigned RW = INP2_RW
) ();

    logic                   clear_i;
    inp2_mode_e             mode_i;
    logic                   calc_en_i;
    logic                   weight_valid_i;
    logic                   weight_ready_o;
    logic [N-1:0][WI-1:0]   weight_i;
    logic [RW-1:0]          reuse_i;
    logic [N-1:0][WI-1:0]   inp2_o;
    logic                   inp2_valid_o;
    logic                   tile_done_o;
    logic                   stall_o;

    modport slave (
        input  clear_i, mode_i, calc_en_i, weight_valid_i, weight_i, reuse_i,
        output weight_ready_o, inp2_o, inp2_valid_o, tile_done_o, stall_o
    );

    modport master (
        output clear_i, mode_i, calc_en_i, weight_valid_i, weight_i, reuse_i,
        input  weight_ready_o, inp2_o, inp2_valid_o, tile_done_o, stall_o
    );

endinterface

// File: rtl/ita_inp2_bank.sv
// Two-entry register file holding {tile, reuse}; async-reset write port, combinational read.
module ita_inp2_bank #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic         waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         raddr_i,
    output logic [W-1:0] rdata_o
);

    logic [1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ita_inp2_buf.sv
// Double-buffered weight operand stage: prefetches tile k+1 while tile k is reused
// for a per-tile number of calc cycles; bypass mode is a plain calc_en-gated pass-through.
module ita_inp2_buf
    import ita_inp2_buf_pkg::*;
#(
    parameter int unsigned N  = INP2_N,
    parameter int unsigned WI = INP2_WI,
    parameter int unsigned RW = INP2_RW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ita_inp2_buf_if.slave      bus
);

    localparam int unsigned TW = N * WI;
    localparam int unsigned EW = TW + RW;

    logic [1:0]    count_q,   count_d;
    logic          wr_ptr_q,  wr_ptr_d;
    logic          rd_ptr_q,  rd_ptr_d;
    logic [RW-1:0] use_cnt_q, use_cnt_d;
    inp2_mode_e    mode_q,    mode_d;

    logic [EW-1:0] rd_data;
    logic [TW-1:0] rd_tile;
    logic [RW-1:0] rd_reuse;
    logic [RW-1:0] eff_reuse;
    logic          bypass, avail, use_tile, last_use, push, pop, ready, bank_we;

    ita_inp2_bank #(.W(EW)) u_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (bank_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.weight_i, bus.reuse_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Handshake and consumption decode; a stored reuse of 0 still means one cycle of use.
    always_comb begin
        bypass    = (bus.mode_i == INP2_BYPASS);
        avail     = (count_q != 2'd0);
        {rd_tile, rd_reuse} = rd_data;
        eff_reuse = (rd_reuse == '0) ? RW'(1) : rd_reuse;
        use_tile  = bus.calc_en_i & avail & !bypass;
        last_use  = (use_cnt_q == (eff_reuse - RW'(1)));
        pop       = use_tile & last_use;
        ready     = bypass ? bus.calc_en_i : ((count_q != 2'd2) & !bus.clear_i);
        push      = bus.weight_valid_i & ready & !bypass;
        bank_we   = push & !bus.clear_i;
    end

    // Outputs are forced low while reset is asserted, including the bypass path.
    always_comb begin
        bus.weight_ready_o = !rst_i & ready;
        bus.tile_done_o    = !rst_i & pop;
        bus.stall_o        = !rst_i & !bypass & bus.calc_en_i & !avail;
        if (rst_i) begin
            bus.inp2_o       = '0;
            bus.inp2_valid_o = 1'b0;
        end else if (bypass) begin
            bus.inp2_o       = bus.calc_en_i ? bus.weight_i : '0;
            bus.inp2_valid_o = bus.calc_en_i & bus.weight_valid_i;
        end else begin
            bus.inp2_o       = use_tile ? rd_tile : '0;
            bus.inp2_valid_o = use_tile;
        end
    end

    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        use_cnt_d = use_cnt_q;
        mode_d    = bus.mode_i;
        if (bus.clear_i) begin
            count_d   = 2'd0;
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            use_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d  = ~rd_ptr_q;
                use_cnt_d = '0;
            end else if (use_tile) begin
                use_cnt_d = use_cnt_q + RW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            use_cnt_q <= '0;
            mode_q    <= INP2_BUF;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            use_cnt_q <= use_cnt_d;
            mode_q    <= mode_d;
        end
    end

    // Switching mode with tiles still buffered leaves the banks in an undefined role.
    mode_change_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.mode_i != mode_q) |-> (count_q == 2'd0))
        else $error("ita_inp2_buf: mode_i changed while tiles are buffered");

endmodule

// File: tb/tb_ita_inp2_buf.sv
// Directed bench for ita_inp2_buf: reset, reuse counting, double buffering, clear, bypass.
module tb_ita_inp2_buf;
    import ita_inp2_buf_pkg::*;

    localparam int unsigned TW = INP2_N * INP2_WI;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ita_inp2_buf_if ifc ();

    ita_inp2_buf dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    weight_t tz, ta, tb, tc, td, te, tf, tg, t5a;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input weight_t e_inp2, input logic e_valid,
                        input logic e_done, input logic e_stall, input logic e_ready);
        #1;
        chk({tag, ".inp2"},  TW'(ifc.inp2_o),         TW'(e_inp2));
        chk({tag, ".valid"}, TW'(ifc.inp2_valid_o),   TW'(e_valid));
        chk({tag, ".done"},  TW'(ifc.tile_done_o),    TW'(e_done));
        chk({tag, ".stall"}, TW'(ifc.stall_o),        TW'(e_stall));
        chk({tag, ".ready"}, TW'(ifc.weight_ready_o), TW'(e_ready));
    endtask

    task automatic set_in(input logic v, input weight_t w, input logic [INP2_RW-1:0] r,
                          input logic cen, input logic clr);
        ifc.weight_valid_i = v;
        ifc.weight_i       = w;
        ifc.reuse_i        = r;
        ifc.calc_en_i      = cen;
        ifc.clear_i        = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tz  = '0;
        ta  = {INP2_N{8'h11}};
        tb  = {INP2_N{8'h22}};
        tc  = {INP2_N{8'h33}};
        td  = {INP2_N{8'h44}};
        te  = {INP2_N{8'h55}};
        tf  = {INP2_N{8'h66}};
        tg  = {INP2_N{8'h77}};
        t5a = {INP2_N{8'h5A}};

        rst = 1'b1;
        ifc.mode_i = INP2_BUF;
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0);
        outs("reset", tz, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Single tile, reuse 3
        set_in(1'b1, ta, 8'd3, 1'b0, 1'b0); outs("a_push",  tz, 0, 0, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0); outs("a_use1",  ta, 1, 0, 0, 1); tick();
        outs("a_use2",  ta, 1, 0, 0, 1); tick();
        outs("a_use3",  ta, 1, 1, 0, 1); tick();
        outs("a_stall", tz, 0, 0, 1, 1); tick();

        // Back-to-back A(2), B(1); C pushed in the same cycle B pops
        set_in(1'b1, ta, 8'd2, 1'b0, 1'b0); outs("bb_push_a", tz, 0, 0, 0, 1); tick();
        set_in(1'b1, tb, 8'd1, 1'b1, 1'b0); outs("bb_a1",     ta, 1, 0, 0, 1); tick();
        set_in(1'b1, tc, 8'd5, 1'b1, 1'b0); outs("bb_a2_full", ta, 1, 1, 0, 0); tick();
        outs("bb_b_pushpop", tb, 1, 1, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0); outs("pp_c",      tc, 1, 0, 0, 1); tick();

        // Clear with a valid offer: no push, outputs from pre-clear state
        set_in(1'b1, td, 8'd7, 1'b1, 1'b1); outs("clr",       tc, 1, 0, 0, 0); tick();
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0); outs("clr_after", tz, 0, 0, 1, 1); tick();

        // Reuse 0 behaves as 1
        set_in(1'b1, td, 8'd0, 1'b0, 1'b0); outs("r0_push",  tz, 0, 0, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0); outs("r0_use",   td, 1, 1, 0, 1); tick();
        outs("r0_stall", tz, 0, 0, 1, 1); tick();

        // Gapped calc_en with reuse 2
        set_in(1'b1, te, 8'd2, 1'b0, 1'b0); outs("gap_push", tz, 0, 0, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0); outs("gap_en1",  te, 1, 0, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b0, 1'b0); outs("gap_idle", tz, 0, 0, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0); outs("gap_en2",  te, 1, 1, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b0, 1'b0); outs("idle",     tz, 0, 0, 0, 1); tick();

        // Bypass pass-through
        ifc.mode_i = INP2_BYPASS;
        set_in(1'b1, t5a, 8'd0, 1'b1, 1'b0); outs("byp_on",   t5a, 1, 0, 0, 1); tick();
        set_in(1'b1, t5a, 8'd0, 1'b0, 1'b0); outs("byp_off",  tz,  0, 0, 0, 0); tick();
        set_in(1'b0, t5a, 8'd0, 1'b1, 1'b0); outs("byp_on2",  t5a, 0, 0, 0, 1); tick();
        set_in(1'b0, t5a, 8'd0, 1'b0, 1'b0); outs("byp_off2", tz,  0, 0, 0, 0); tick();
        ifc.mode_i = INP2_BUF;
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0);  outs("byp_cnt0", tz,  0, 0, 1, 1); tick();

        // Reset in the middle of operation with both banks full
        set_in(1'b1, tf, 8'd4, 1'b0, 1'b0); tick();
        set_in(1'b1, tg, 8'd4, 1'b0, 1'b0); tick();
        set_in(1'b1, tf, 8'd4, 1'b1, 1'b0); outs("full", tf, 1, 0, 0, 0);
        rst = 1'b1;
        outs("rst_mid", tz, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        set_in(1'b0, tz, 8'd0, 1'b0, 1'b0); outs("rst_rel",  tz, 0, 0, 0, 1); tick();
        set_in(1'b0, tz, 8'd0, 1'b1, 1'b0); outs("rst_cnt0", tz, 0, 0, 1, 1); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ita_inp2_buf.md
Name: ita_inp2_buf

Overview:
- Double-buffered staging for the PE array's second operand (weights); successor to the single-cycle, calc_en-gated weight pass-through.
- Accepts weight tiles over a valid/ready handshake and presents each tile on inp2_o for a per-tile programmable number of calc cycles, then swaps banks.
- Prefetch of tile k+1 overlaps use of tile k.
- Bypass mode reproduces the plain gated pass-through.

Parameters:
- N, default 64: lanes per weight tile.
- WI, default 8: bits per weight lane.
- RW, default 8: width of the reuse count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous flush of both banks.
- mode_i  in  1  0 = buffered, 1 = bypass; quasi-static.
- calc_en_i  in  1  PE array consumes the operand this cycle.
- weight_valid_i  in  1  tile offered.
- weight_ready_o  out  1  tile accepted when valid & ready.
- weight_i  in  N*WI  weight tile.
- reuse_i  in  RW  calc cycles this tile is used; sampled with the handshake.
- inp2_o  out  N*WI  operand to the PE array.
- inp2_valid_o  out  1  inp2_o carries a real tile this cycle.
- tile_done_o  out  1  current cycle is the last use of the front tile.
- stall_o  out  1  calc_en_i high but no tile available.

Behaviour:
- Reset (rst_i high, async):
  - count=0, wr_ptr=0, rd_ptr=0, use_cnt=0; both banks and stored reuse values = 0.
  - inp2_o=0, inp2_valid_o=0, tile_done_o=0, stall_o=0, weight_ready_o=0 while rst_i is high.
- Storage: 2 banks, each holding {tile, reuse}. count ∈ {0,1,2}.
- Buffered mode (mode_i=0):
  - weight_ready_o = (count<2) & !clear_i.
  - Push on valid & ready: bank[wr_ptr] <= {weight_i, reuse_i}; wr_ptr toggles.
  - A pushed tile is visible on inp2_o the next cycle (1-cycle latency); no same-cycle forwarding.
  - Output is combinational from bank[rd_ptr]:
    - calc_en_i & count>0: inp2_o = bank tile, inp2_valid_o=1.
    - Otherwise: inp2_o=0, inp2_valid_o=0.
  - eff_reuse = (stored reuse==0) ? 1 : stored reuse.
  - Each cycle with calc_en_i & count>0:
    - if use_cnt == eff_reuse-1: tile_done_o=1 that cycle; pop (rd_ptr toggles, use_cnt=0).
    - else use_cnt++.
  - Stall: stall_o = calc_en_i & count==0. inp2_o=0, use_cnt unchanged, no pop.
  - count update per cycle: push only +1; pop only -1; push & pop same cycle: unchanged.
  - No push is possible at count==2, even if a pop occurs the same cycle (ready is registered-state based only).
  - calc_en_i low: no state change except a push.
- Bypass mode (mode_i=1):
  - inp2_o = calc_en_i ? weight_i : 0; inp2_valid_o = calc_en_i & weight_valid_i.
  - weight_ready_o = calc_en_i.
  - Banks, pointers, count and use_cnt are frozen; tile_done_o=0, stall_o=0.
- Mode changes are legal only when count==0. A simulation assertion flags violations; RTL behaviour in that case is unspecified.
- clear_i:
  - Next cycle: count=0, pointers=0, use_cnt=0. Bank contents are retained but invalid.
  - Clear overrides a push and a pop in the same cycle.
  - Outputs in the clear cycle follow the pre-clear state.
- Widths: use_cnt is RW bits; reuse up to 2^RW-1 cycles per tile.

Decomposition:
- ita_package gains:
  - inp2_mode_e {INP2_BUF, INP2_BYPASS}.
  - reuse_t = logic [RW-1:0] with the package default RW.
  - The existing weight_t generalised as logic [N-1:0][WI-1:0].
- One natural sub-module: ita_inp2_bank, a 2-entry register file with async-reset write port and combinational read port. Pointers and counters stay in the top.

Test Plan:
- Reset mid-operation: count=2, rst_i pulsed high for 1 cycle → inp2_o=0, ready=0 during reset; ready=1 next cycle, count=0.
- Single tile, reuse=3: push tile A, calc_en_i held high → A on inp2_o for exactly 3 cycles, tile_done_o on the 3rd, then stall_o=1 and inp2_o=0.
- Back-to-back tiles A (reuse=2) and B (reuse=1), continuous calc_en_i → output sequence A,A,B with no gap. Ready drops to 0 after 2 pushes and returns in the cycle after A's pop.
- reuse_i=0 → treated as 1: one cycle of use, tile_done_o=1. Gapped calc_en_i (1,0,1) with reuse=2 → tile_done_o only on the second enabled cycle.
- Simultaneous push and pop at count=1 → count stays 1, next tile appears on the cycle after the pop. clear_i together with valid → no push, count=0.
- Bypass: mode_i=1, weight_i=0x5A per lane, calc_en_i toggling → inp2_o alternates 0x5A/0; count stays 0; tile_done_o never asserted.
